// File: rtl/udp_rx_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// udp_rx_buffer - stores whole UDP payloads in a byte RAM plus a length
// queue for the CPU read port; UDP_RX_DROP_CNT_EN adds drop_cnt. Rev 1.0
// ---------------------------------------------------------------------------
module udp_rx_buffer #(
  parameter int ADDR_W = 11,
  parameter int LQ_W   = 2,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic             rx_udp_data_v,
  input  logic [7:0]       rx_udp_data,
  output logic             pkt_avail,
  output logic [LEN_W-1:0] pkt_len,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             rd_last,
  output logic             pkt_irq
`ifdef UDP_RX_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int               DEPTH    = 1 << ADDR_W;
  localparam int               LQ_DEPTH = 1 << LQ_W;
  localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LQ_W:0]    LQ_ONE   = {{LQ_W{1'b0}}, 1'b1};
  localparam logic [LQ_W:0]    LQ_FULL  = {1'b1, {LQ_W{1'b0}}};

  logic [7:0]       ram [DEPTH];
  logic [7:0]       ram_q;
  logic [ADDR_W:0]  wr_ptr, rd_ptr, wr_commit, used;
  logic [LEN_W-1:0] cur_len, rd_off;
  logic [LEN_W-1:0] lq [LQ_DEPTH];
  logic [LQ_W:0]    lq_wr, lq_rd, lq_cnt;
  logic             armed, prev_v, ovf;
  logic             wr_fire, ovf_hit, eop, commit, rd_fire, rd_final;

  assign used      = wr_ptr - rd_ptr;
  assign lq_cnt    = lq_wr - lq_rd;
  assign pkt_avail = (lq_cnt != '0);
  assign pkt_len   = lq[lq_rd[LQ_W-1:0]];

  // used counts uncommitted bytes too, so a packet can never overrun unread data
  assign wr_fire  = rx_udp_data_v & armed & ~ovf & (used < PTR_FULL);
  assign ovf_hit  = rx_udp_data_v & armed & ~ovf & ~(used < PTR_FULL);
  assign eop      = armed & prev_v & ~rx_udp_data_v;
  assign commit   = eop & ~ovf & (cur_len != '0) & (lq_cnt != LQ_FULL);
  assign rd_fire  = rd_en & pkt_avail;
  assign rd_final = rd_fire & ((rd_off + LEN_ONE) == pkt_len);

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      prev_v    <= 1'b0;
      ovf       <= 1'b0;
      cur_len   <= '0;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      prev_v <= rx_udp_data_v;
      if (!rx_udp_data_v) armed <= 1'b1;
      if (eop) begin
        cur_len <= '0;
        ovf     <= 1'b0;
        if (commit) wr_commit <= wr_ptr;
        else        wr_ptr    <= wr_commit;
      end else begin
        if (wr_fire) begin
          wr_ptr  <= wr_ptr + PTR_ONE;
          cur_len <= cur_len + LEN_ONE;
        end
        if (ovf_hit) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      lq_wr   <= '0;
      lq_rd   <= '0;
      rd_off  <= '0;
      pkt_irq <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) lq[i] <= '0;
    end else begin
      pkt_irq <= commit;
      if (commit) begin
        lq[lq_wr[LQ_W-1:0]] <= cur_len;
        lq_wr               <= lq_wr + LQ_ONE;
      end
      if (rd_fire) rd_off <= rd_final ? '0 : rd_off + LEN_ONE;
      if (rd_final) lq_rd <= lq_rd + LQ_ONE;
    end
  end

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_final;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Plain block RAM: no reset on the array or its read register
  always_ff @(posedge RX_CLK) begin
    if (wr_fire) ram[wr_ptr[ADDR_W-1:0]] <= rx_udp_data;
    if (rd_fire) ram_q <= ram[rd_ptr[ADDR_W-1:0]];
  end

  assign rd_data = rd_valid ? ram_q : 8'h00;

`ifdef UDP_RX_DROP_CNT_EN
  logic drop;
  assign drop = eop & ~commit;

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst)                            drop_cnt <= 16'h0000;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h0001;
  end
`endif

endmodule
`default_nettype wire
